// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the CPU/DMA memory port arbiter: state encoding, owner codes, default bus widths.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    // Default widths shared by the controller, datapath and memory macro
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // Arbiter state encoding (legacy-compatible constants)
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Grant owner codes
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    // Counter widths: latency counter holds MEM_LAT directly (up to 8),
    // starve counter holds MAX_WAIT (up to 15)
    localparam int LAT_CNT_W = 4;
    localparam int STARVE_W  = 4;

    // Saturating increment used by the starvation guard
    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] val,
                                                    input logic [STARVE_W-1:0] lim);
        return (val >= lim) ? lim : val + 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between a CPU port (fixed priority) and a DMA port (starvation-guarded).
// Latency: request in IDLE cycle 0 -> mem_en cycle 1 -> WAIT for MEM_LAT cycles -> ack in cycle MEM_LAT+2; one access per MEM_LAT+3 cycles.
// Backpressure: req is held until its one-cycle ack; requests arriving while busy wait for the next IDLE cycle.
//
// Ports:
//   clock, reset_n                   : clock (rising edge), asynchronous active-low reset
//   cpu_req/we/addr/wdata -> cpu_ack/rdata : CPU request set and its completion pulse / registered read data
//   dma_req/we/addr/wdata -> dma_ack/rdata : DMA request set, same meaning as the CPU set
//   mem_en/we/addr/wdata, mem_rdata  : memory macro interface (rdata valid MEM_LAT cycles after mem_en)
//   busy, owner                      : high in ISSUE/WAIT/DONE; current/last grant (0 = CPU, 1 = DMA)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              owner
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD  = LAT_CNT_W'(MEM_LAT);
    localparam logic [STARVE_W-1:0]  STARVE_LIM = STARVE_W'(MAX_WAIT);

    logic [1:0]           state;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic [STARVE_W-1:0]  starve_cnt;

    logic any_req;
    logic grant_dma;

    // DMA wins when it is alone, or when it has lost MAX_WAIT contested rounds in a row
    assign any_req   = cpu_req | dma_req;
    assign grant_dma = dma_req & (~cpu_req | (starve_cnt == STARVE_LIM));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
            busy       <= 1'b0;
            owner      <= OWN_CPU;
        end else begin
            // Strobes are single-cycle; they are only raised on the state transitions below
            mem_en  <= 1'b0;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        state  <= ISSUE;
                        busy   <= 1'b1;
                        mem_en <= 1'b1;
                        if (grant_dma) begin
                            owner      <= OWN_DMA;
                            mem_we     <= dma_we;
                            mem_addr   <= dma_addr;
                            mem_wdata  <= dma_wdata;
                            starve_cnt <= '0;
                        end else begin
                            owner     <= OWN_CPU;
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                            // Only a contested CPU win counts against the DMA port
                            if (dma_req) begin
                                starve_cnt <= sat_inc(starve_cnt, STARVE_LIM);
                            end
                        end
                    end
                end

                ISSUE: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= WAIT;
                end

                WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    // lat_cnt == 1 marks the cycle in which mem_rdata is valid
                    if (lat_cnt == LAT_CNT_W'(1)) begin
                        state <= DONE;
                        if (owner == OWN_DMA) begin
                            dma_ack <= 1'b1;
                            if (!mem_we) begin
                                dma_rdata <= mem_rdata;
                            end
                        end else begin
                            cpu_ack <= 1'b1;
                            if (!mem_we) begin
                                cpu_rdata <= mem_rdata;
                            end
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: one instance at MEM_LAT=1 (CPU read), one at MEM_LAT=3 (DMA, contention, reset abort).
// Latency: n/a.
// Backpressure: requesters hold req until ack, as the arbiter expects.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- instance with MEM_LAT = 1 (CPU port only) ----------------
    logic        c1_req = 1'b0, c1_we = 1'b0;
    logic [15:0] c1_addr = '0, c1_wdata = '0;
    logic        d1_cpu_ack, d1_dma_ack, d1_mem_en, d1_mem_we, d1_busy, d1_owner;
    logic [15:0] d1_cpu_rdata, d1_dma_rdata, d1_mem_addr, d1_mem_wdata, d1_mem_rdata;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .MAX_WAIT(4)) u_dut1 (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
        .cpu_ack(d1_cpu_ack), .cpu_rdata(d1_cpu_rdata),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(16'h0000), .dma_wdata(16'h0000),
        .dma_ack(d1_dma_ack), .dma_rdata(d1_dma_rdata),
        .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
        .mem_rdata(d1_mem_rdata), .busy(d1_busy), .owner(d1_owner)
    );

    // ---------------- instance with MEM_LAT = 3 ----------------
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;
    logic        d3_cpu_ack, d3_dma_ack, d3_mem_en, d3_mem_we, d3_busy, d3_owner;
    logic [15:0] d3_cpu_rdata, d3_dma_rdata, d3_mem_addr, d3_mem_wdata, d3_mem_rdata;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3), .MAX_WAIT(4)) u_dut3 (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(d3_cpu_ack), .cpu_rdata(d3_cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(d3_dma_ack), .dma_rdata(d3_dma_rdata),
        .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata),
        .mem_rdata(d3_mem_rdata), .busy(d3_busy), .owner(d3_owner)
    );

    // ---------------- memory models: read data appears MEM_LAT cycles after mem_en ----------------
    logic        ld_en = 1'b0;
    logic [9:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [15:0] mem1 [0:1023];
    logic [15:0] mem3 [0:1023];
    logic [15:0] pipe1;
    logic [15:0] pipe3 [0:2];

    always @(posedge clock) begin
        if (ld_en) mem1[ld_addr] <= ld_data;
        else if (d1_mem_en && d1_mem_we) mem1[d1_mem_addr[9:0]] <= d1_mem_wdata;
        pipe1 <= (d1_mem_en && !d1_mem_we) ? mem1[d1_mem_addr[9:0]] : 16'hDEAD;
    end
    assign d1_mem_rdata = pipe1;

    always @(posedge clock) begin
        if (ld_en) mem3[ld_addr] <= ld_data;
        else if (d3_mem_en && d3_mem_we) mem3[d3_mem_addr[9:0]] <= d3_mem_wdata;
        pipe3[0] <= (d3_mem_en && !d3_mem_we) ? mem3[d3_mem_addr[9:0]] : 16'hDEAD;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign d3_mem_rdata = pipe3[2];

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        @(negedge clock);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    // One access on the MEM_LAT=3 instance; cycle k is sampled at the negedge after the k-th rising edge
    task automatic access3(input logic port, input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           output int ack_cyc, output int en_cnt, output int en_cyc,
                           output logic [32:0] en_fields, output logic other_ack);
        ack_cyc = -1; en_cnt = 0; en_cyc = -1; en_fields = '0; other_ack = 1'b0;
        @(negedge clock);
        if (port) begin dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata; end
        else      begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (d3_mem_en) begin
                en_cnt++; en_cyc = k; en_fields = {d3_mem_we, d3_mem_addr, d3_mem_wdata};
            end
            if ((port ? d3_dma_ack : d3_cpu_ack) && ack_cyc < 0) begin
                ack_cyc = k;
                if (port) dma_req = 1'b0; else cpu_req = 1'b0;
            end
            if (port ? d3_cpu_ack : d3_dma_ack) other_ack = 1'b1;
        end
    endtask

    function automatic logic [69:0] bundle3();
        return {d3_mem_en, d3_mem_we, d3_mem_addr, d3_mem_wdata, d3_cpu_ack, d3_dma_ack,
                d3_cpu_rdata, d3_dma_rdata, d3_busy, d3_owner};
    endfunction

    function automatic logic [69:0] bundle1();
        return {d1_mem_en, d1_mem_we, d1_mem_addr, d1_mem_wdata, d1_cpu_ack, d1_dma_ack,
                d1_cpu_rdata, d1_dma_rdata, d1_busy, d1_owner};
    endfunction

    initial begin
        int          ack_cyc, en_cnt, en_cyc, ng, nacks;
        logic [32:0] en_fields;
        logic        oth;
        logic [69:0] acc1, acc3;
        logic        grants [0:10];
        logic [10:0] exp_seq;
        logic        last_own;

        // ---------- reset then idle ----------
        repeat (2) @(negedge clock);
        check_eq("rst_hold_d3", 80'(bundle3()), 80'(0));
        reset_n = 1'b1;
        acc1 = '0; acc3 = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            acc1 |= bundle1(); acc3 |= bundle3();
        end
        check_eq("idle_d1", 80'(acc1), 80'(0));
        check_eq("idle_d3", 80'(acc3), 80'(0));

        // ---------- single CPU read, MEM_LAT=1 ----------
        preload(10'h010, 16'hBEEF);
        @(negedge clock);
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 16'h0010;
        ack_cyc = -1; en_cyc = -1; en_cnt = 0; oth = 1'b0; en_fields = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (d1_mem_en) begin en_cnt++; en_cyc = k; en_fields = {d1_mem_we, d1_mem_addr, d1_mem_wdata}; end
            if (d1_cpu_ack && ack_cyc < 0) begin ack_cyc = k; c1_req = 1'b0; end
            if (d1_dma_ack) oth = 1'b1;
        end
        check_eq("l1_en_cyc", 80'(en_cyc), 80'(1));
        check_eq("l1_en_cnt", 80'(en_cnt), 80'(1));
        check_eq("l1_mem_addr", 80'(en_fields[31:16]), 80'(16'h0010));
        check_eq("l1_ack_cyc", 80'(ack_cyc), 80'(3));
        check_eq("l1_rdata", 80'(d1_cpu_rdata), 80'(16'hBEEF));
        check_eq("l1_dma_ack", 80'(oth), 80'(0));
        check_eq("l1_owner", 80'(d1_owner), 80'(OWN_CPU));
        check_eq("l1_busy_end", 80'(d1_busy), 80'(0));

        // ---------- DMA read then DMA write, MEM_LAT=3 ----------
        preload(10'h300, 16'h5A5A);
        access3(1'b1, 1'b0, 16'h0300, 16'h0000, ack_cyc, en_cnt, en_cyc, en_fields, oth);
        check_eq("dr_ack_cyc", 80'(ack_cyc), 80'(5));
        check_eq("dr_fields", 80'(en_fields), 80'({1'b0, 16'h0300, 16'h0000}));
        check_eq("dr_rdata", 80'(d3_dma_rdata), 80'(16'h5A5A));
        check_eq("dr_cpu_rdata", 80'(d3_cpu_rdata), 80'(0));
        check_eq("dr_owner", 80'(d3_owner), 80'(OWN_DMA));

        access3(1'b1, 1'b1, 16'h0200, 16'h1234, ack_cyc, en_cnt, en_cyc, en_fields, oth);
        check_eq("dw_en_cnt", 80'(en_cnt), 80'(1));
        check_eq("dw_en_cyc", 80'(en_cyc), 80'(1));
        check_eq("dw_fields", 80'(en_fields), 80'({1'b1, 16'h0200, 16'h1234}));
        check_eq("dw_ack_cyc", 80'(ack_cyc), 80'(5));
        check_eq("dw_cpu_ack", 80'(oth), 80'(0));
        check_eq("dw_rdata_held", 80'(d3_dma_rdata), 80'(16'h5A5A));
        check_eq("dw_mem", 80'(mem3[10'h200]), 80'(16'h1234));

        access3(1'b0, 1'b0, 16'h0200, 16'h0000, ack_cyc, en_cnt, en_cyc, en_fields, oth);
        check_eq("cr_ack_cyc", 80'(ack_cyc), 80'(5));
        check_eq("cr_rdata", 80'(d3_cpu_rdata), 80'(16'h1234));
        check_eq("cr_dma_rdata", 80'(d3_dma_rdata), 80'(16'h5A5A));

        // ---------- contention: CPU alone first, DMA joins while busy, both then hold req ----------
        // Grant 0 uncontested; contested grants run C,C,C,C,D repeating from starve_cnt=0
        exp_seq = 11'b100_0010_0000;
        ng = 0; nacks = 0; last_own = OWN_CPU;
        for (int i = 0; i < 11; i++) grants[i] = 1'bx;
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clock);
            if (k == 2) begin dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0300; end
            if (d3_mem_en) begin
                last_own = d3_owner;
                if (ng < 11) grants[ng] = d3_owner;
                ng++;
            end
            if (d3_cpu_ack || d3_dma_ack) begin
                check_eq("cont_ack", 80'({d3_cpu_ack, d3_dma_ack}), 80'(last_own ? 2'b01 : 2'b10));
                nacks++;
                if (nacks == 11) begin cpu_req = 1'b0; dma_req = 1'b0; break; end
            end
        end
        check_eq("cont_ngrants", 80'(ng), 80'(11));
        for (int i = 0; i < 11; i++) begin
            check_eq($sformatf("cont_grant%0d", i), 80'(grants[i]), 80'(exp_seq[i]));
        end
        repeat (3) @(negedge clock);
        check_eq("cont_idle", 80'(d3_busy), 80'(0));

        // ---------- reset in the middle of a DMA read ----------
        preload(10'h300, 16'h7777);
        @(negedge clock);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0300;
        repeat (2) @(negedge clock);   // cycle 2: first WAIT cycle
        check_eq("ab_busy", 80'(d3_busy), 80'(1));
        #2 reset_n = 1'b0;
        #1;
        check_eq("ab_outs_d3", 80'(bundle3()), 80'(0));
        check_eq("ab_outs_d1", 80'(bundle1()), 80'(0));
        dma_req = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        oth = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (d3_dma_ack || d3_cpu_ack || d3_busy) oth = 1'b1;
        end
        check_eq("ab_no_ack", 80'(oth), 80'(0));
        preload(10'h040, 16'hC0DE);
        access3(1'b0, 1'b0, 16'h0040, 16'h0000, ack_cyc, en_cnt, en_cyc, en_fields, oth);
        check_eq("ab_cr_ack_cyc", 80'(ack_cyc), 80'(5));
        check_eq("ab_cr_rdata", 80'(d3_cpu_rdata), 80'(16'hC0DE));
        check_eq("ab_cr_dma_ack", 80'(oth), 80'(0));
        check_eq("ab_dma_rdata", 80'(d3_dma_rdata), 80'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
